// File: rtl/sid_envelope.sv
// sid_envelope: per-voice ADSR envelope generator and amplitude multiplier.
//
// Ports:
//   clk      - system clock
//   n_reset  - asynchronous active-low reset
//   clk_en   - SID cycle enable; all state advances only when high
//   gate     - GATE control bit; rising edge starts attack, falling edge starts release
//   reg_atk  - attack rate index
//   reg_dec  - decay rate index
//   reg_sus  - sustain level (upper and lower nibble of the 8-bit target)
//   reg_rel  - release rate index
//   wave     - unsigned 12-bit oscillator waveform
//   env_out  - current 8-bit envelope value
//   v_out    - enveloped voice sample, (wave * env) >> 8, lags env by one clk_en
//
// Build option: define SID_ENV_EXP_EN to enable the exponential decay/release divider.
// Without it decay and release are linear (one step per rate tick).

module sid_envelope #(
  parameter int unsigned RATE_W = 15
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        clk_en,
  input  logic        gate,
  input  logic [3:0]  reg_atk,
  input  logic [3:0]  reg_dec,
  input  logic [3:0]  reg_sus,
  input  logic [3:0]  reg_rel,
  input  logic [11:0] wave,
  output logic [7:0]  env_out,
  output logic [11:0] v_out
);

  typedef enum logic [1:0] {StAttack, StDecaySus, StRelease} state_e;

  state_e             state_q, state_d, state_sel;
  logic               gate_q, gate_d;
  logic [RATE_W-1:0]  rate_q, rate_d, period;
  logic [7:0]         env_q, env_d;
  logic [11:0]        v_q, v_d;
  logic [3:0]         rate_idx;
  logic               tick;
  logic [7:0]         floor_lvl;
  logic [19:0]        prod;
  logic               exp_hit;

  assign prod = 20'(wave) * 20'(env_q);

  // Rate period lookup for the index selected by the (post-edge) state.
  always_comb begin
    period = RATE_W'(9);
    unique case (rate_idx)
      4'd0:  period = RATE_W'(9);
      4'd1:  period = RATE_W'(32);
      4'd2:  period = RATE_W'(63);
      4'd3:  period = RATE_W'(95);
      4'd4:  period = RATE_W'(149);
      4'd5:  period = RATE_W'(220);
      4'd6:  period = RATE_W'(267);
      4'd7:  period = RATE_W'(313);
      4'd8:  period = RATE_W'(392);
      4'd9:  period = RATE_W'(977);
      4'd10: period = RATE_W'(1954);
      4'd11: period = RATE_W'(3126);
      4'd12: period = RATE_W'(3907);
      4'd13: period = RATE_W'(11720);
      4'd14: period = RATE_W'(19532);
      4'd15: period = RATE_W'(31251);
      default: period = RATE_W'(9);
    endcase
  end

`ifdef SID_ENV_EXP_EN
  logic [4:0] exp_q, exp_d, exp_period;

  always_comb begin
    exp_period = 5'd1;
    if (env_q >= 8'd94)      exp_period = 5'd1;
    else if (env_q >= 8'd55) exp_period = 5'd2;
    else if (env_q >= 8'd27) exp_period = 5'd4;
    else if (env_q >= 8'd15) exp_period = 5'd8;
    else if (env_q >= 8'd7)  exp_period = 5'd16;
    else if (env_q >= 8'd1)  exp_period = 5'd30;
    else                     exp_period = 5'd1;
  end

  assign exp_hit = (exp_q == exp_period - 5'd1);
`else
  assign exp_hit = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    rate_d    = rate_q;
    env_d     = env_q;
    v_d       = v_q;
`ifdef SID_ENV_EXP_EN
    exp_d     = exp_q;
`endif
    // Gate edges take effect before the tick so a coincident tick uses the new state.
    state_sel = state_q;
    if (gate && !gate_q)      state_sel = StAttack;
    else if (!gate && gate_q) state_sel = StRelease;

    unique case (state_sel)
      StAttack:   rate_idx = reg_atk;
      StDecaySus: rate_idx = reg_dec;
      default:    rate_idx = reg_rel;
    endcase

    // Equality-only compare: lowering the period below the count forces a full wrap.
    tick      = (rate_q == period - RATE_W'(1));
    floor_lvl = (state_sel == StDecaySus) ? {reg_sus, reg_sus} : 8'd0;

    if (clk_en) begin
      state_d = state_sel;
      gate_d  = gate;
      rate_d  = tick ? '0 : rate_q + RATE_W'(1);
      v_d     = prod[19:8];
      if (tick) begin
        if (state_sel == StAttack) begin
`ifdef SID_ENV_EXP_EN
          exp_d = 5'd0;
`endif
          if (env_q != 8'hFF) env_d   = env_q + 8'd1;
          else                state_d = StDecaySus;
        end else begin
`ifdef SID_ENV_EXP_EN
          exp_d = exp_hit ? 5'd0 : exp_q + 5'd1;
`endif
          // Zero guard keeps env from wrapping when sustain sits above env.
          if (exp_hit && env_q != floor_lvl && env_q != 8'd0) env_d = env_q - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= StRelease;
      gate_q  <= 1'b0;
      rate_q  <= '0;
      env_q   <= 8'd0;
      v_q     <= 12'd0;
`ifdef SID_ENV_EXP_EN
      exp_q   <= 5'd0;
`endif
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      rate_q  <= rate_d;
      env_q   <= env_d;
      v_q     <= v_d;
`ifdef SID_ENV_EXP_EN
      exp_q   <= exp_d;
`endif
    end
  end

  assign env_out = env_q;
  assign v_out   = v_q;

endmodule

// File: tb/tb_sid_envelope.sv
// Testbench for sid_envelope: behavioural ADSR model compared every cycle, plus
// hand-computed literal checks of the key timing points.
module tb_sid_envelope;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        clk_en = 1'b1;
  logic        gate = 1'b0;
  logic [3:0]  reg_atk = 4'd0;
  logic [3:0]  reg_dec = 4'd0;
  logic [3:0]  reg_sus = 4'd8;
  logic [3:0]  reg_rel = 4'd0;
  logic [11:0] wave = 12'hFFF;
  logic [7:0]  env_out;
  logic [11:0] v_out;

  int n_chk = 0;
  int n_pass = 0;

  sid_envelope #(.RATE_W(15)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .clk_en  (clk_en),
    .gate    (gate),
    .reg_atk (reg_atk),
    .reg_dec (reg_dec),
    .reg_sus (reg_sus),
    .reg_rel (reg_rel),
    .wave    (wave),
    .env_out (env_out),
    .v_out   (v_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 attack, 1 decay/sustain, 2 release.
  int periods [16] = '{9, 32, 63, 95, 149, 220, 267, 313, 392, 977, 1954, 3126, 3907,
                       11720, 19532, 31251};
  int m_env = 0, m_v = 0, m_ph = 2, m_rate = 0, m_exp = 0, m_gate = 0;
  int m_idx, m_floor, m_div;
  bit m_tick;

  function automatic int exp_div(input int e);
`ifdef SID_ENV_EXP_EN
    if (e >= 94) return 1;
    if (e >= 55) return 2;
    if (e >= 27) return 4;
    if (e >= 15) return 8;
    if (e >= 7)  return 16;
    if (e >= 1)  return 30;
    return 1;
`else
    return (e >= 0) ? 1 : 1;
`endif
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge n_reset);
      if (!n_reset) begin
        m_env = 0; m_v = 0; m_ph = 2; m_rate = 0; m_exp = 0; m_gate = 0;
      end else if (clk_en) begin
        m_v = (int'(wave) * m_env) / 256;
        if (gate && m_gate == 0)      m_ph = 0;
        else if (!gate && m_gate == 1) m_ph = 2;
        m_gate = int'(gate);
        m_idx  = (m_ph == 0) ? int'(reg_atk) : (m_ph == 1) ? int'(reg_dec) : int'(reg_rel);
        m_tick = (m_rate == periods[m_idx] - 1);
        m_rate = m_tick ? 0 : (m_rate + 1) % 32768;
        if (m_tick) begin
          if (m_ph == 0) begin
            m_exp = 0;
            if (m_env < 255) m_env = m_env + 1;
            else             m_ph = 1;
          end else begin
            m_floor = (m_ph == 1) ? int'(reg_sus) * 17 : 0;
            m_div   = exp_div(m_env);
            if (m_exp >= m_div - 1) begin
              m_exp = 0;
              if (m_env != m_floor && m_env > 0) m_env = m_env - 1;
            end else begin
              m_exp = m_exp + 1;
            end
          end
        end
      end
    end
  end

  // Continuous compare away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("env_model", int'(env_out), m_env);
      chk("vout_model", int'(v_out), m_v);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    #1;
    chk("reset_env", int'(env_out), 0);
    chk("reset_vout", int'(v_out), 0);
    @(posedge clk);
    #1;
    n_reset = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();

    // Idle release with full-scale wave stays silent.
    cyc(1000);
    chk("idle_env", int'(env_out), 0);
    chk("idle_vout", int'(v_out), 0);

    // Fastest attack from a fresh counter: 255 ticks x 9.
    do_reset();
    gate = 1'b1;
    cyc(2294);
    chk("atk_2294", int'(env_out), 254);
    cyc(1);
    chk("atk_2295", int'(env_out), 255);
    cyc(1);
    chk("atk_vout", int'(v_out), 4079);

    // Decay to sustain 0x88: one tick after peak to enter decay, then 119 steps.
    cyc(1078);
    chk("dec_3374", int'(env_out), 137);
    cyc(1);
    chk("dec_3375", int'(env_out), 136);
    wave = 12'h123;
    cyc(1);
    chk("vout_123", int'(v_out), 154);
    wave = 12'h800;
    cyc(1);
    chk("vout_800", int'(v_out), 1088);
    wave = 12'hFFF;
    cyc(9997);
    chk("sustain_hold", int'(env_out), 136);

    // Release to zero; counter is at zero phase here.
    gate = 1'b0;
`ifndef SID_ENV_EXP_EN
    cyc(1223);
    chk("rel_1223", int'(env_out), 1);
    cyc(1);
    chk("rel_1224", int'(env_out), 0);
`endif
    cyc(7000);
    chk("rel_floor", int'(env_out), 0);

    // Delay bug: lowering the period below the count forces a wrap through 32767.
    do_reset();
    reg_atk = 4'd15;
    gate = 1'b1;
    cyc(100);
    reg_atk = 4'd0;
    cyc(32676);
    chk("bug_before", int'(env_out), 0);
    cyc(1);
    chk("bug_tick", int'(env_out), 1);

    // Freeze with clk_en low mid-attack.
    cyc(45);
    chk("pre_freeze_env", int'(env_out), 6);
    chk("pre_freeze_vout", int'(v_out), 79);
    clk_en = 1'b0;
    cyc(500);
    chk("frozen_env", int'(env_out), 6);
    chk("frozen_vout", int'(v_out), 79);
    clk_en = 1'b1;
    cyc(1);
    chk("thaw_vout", int'(v_out), 95);
    chk("thaw_env", int'(env_out), 6);

    // Into decay, then an asynchronous reset pulse between clock edges.
    cyc(2500);
    #2;
    n_reset = 1'b0;
    #1;
    chk("async_env", int'(env_out), 0);
    chk("async_vout", int'(v_out), 0);
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    cyc(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
